// File: rtl/plic_reg_arbiter.sv
// Round-robin register-bus arbiter. It accepts one request at a time from
// num_req_p requesters, issues it to a single host port, and waits for the
// host response with a timeout. It routes the response back to the owning
// requester. After a timeout, a late host response is absorbed by a drain.
module plic_reg_arbiter #(
  parameter int unsigned addr_width_p     = 32,
  parameter int unsigned data_width_p     = 32,
  parameter int unsigned num_req_p        = 2,
  parameter int unsigned timeout_cycles_p = 1024
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,

  input  logic [num_req_p-1:0]              req_v_i,
  output logic [num_req_p-1:0]              req_ready_and_o,
  input  logic [num_req_p*addr_width_p-1:0] req_addr_i,
  input  logic [num_req_p-1:0]              req_we_i,
  input  logic [num_req_p*data_width_p-1:0] req_wdata_i,

  output logic [num_req_p-1:0]              resp_v_o,
  input  logic [num_req_p-1:0]              resp_ready_and_i,
  output logic [data_width_p-1:0]           resp_rdata_o,
  output logic                              resp_err_o,

  output logic                              host_req_o,
  input  logic                              host_gnt_i,
  output logic [addr_width_p-1:0]           host_addr_o,
  output logic                              host_we_o,
  output logic [data_width_p-1:0]           host_wdata_o,
  output logic [data_width_p/8-1:0]         host_be_o,
  input  logic                              host_valid_i,
  input  logic [data_width_p-1:0]           host_rdata_i,
  input  logic                              host_err_i
);

  localparam int unsigned rr_w_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int unsigned cnt_w_lp = $clog2(timeout_cycles_p);
  localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(timeout_cycles_p - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_e;

  state_e                    state_r, state_n;
  logic [rr_w_lp-1:0]        rr_r, rr_n;
  logic [rr_w_lp-1:0]        owner_r, owner_n;
  logic [cnt_w_lp-1:0]       cnt_r, cnt_n;
  logic                      timed_out_r, timed_out_n;
  logic [addr_width_p-1:0]   addr_r, addr_n;
  logic                      we_r, we_n;
  logic [data_width_p-1:0]   wdata_r, wdata_n;
  logic [data_width_p-1:0]   rdata_r, rdata_n;
  logic                      err_r, err_n;

  logic                      grant_found;
  logic [rr_w_lp-1:0]        grant_idx;
  logic [addr_width_p-1:0]   sel_addr;
  logic                      sel_we;
  logic [data_width_p-1:0]   sel_wdata;
  logic [num_req_p-1:0]      owner_mask;

  // Round-robin pick: scan from rr_r to the top, then wrap from 0 to rr_r-1
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      if (!grant_found && req_v_i[i] && (32'(rr_r) <= i)) begin
        grant_found = 1'b1;
        grant_idx   = rr_w_lp'(i);
      end
    end
    for (int unsigned i = 0; i < num_req_p; i++) begin
      if (!grant_found && req_v_i[i]) begin
        grant_found = 1'b1;
        grant_idx   = rr_w_lp'(i);
      end
    end
  end

  // Select the granted requester's request fields
  always_comb begin
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      if (32'(grant_idx) == i) begin
        sel_addr  = req_addr_i[i*addr_width_p +: addr_width_p];
        sel_we    = req_we_i[i];
        sel_wdata = req_wdata_i[i*data_width_p +: data_width_p];
      end
    end
  end

  assign owner_mask = num_req_p'(1) << owner_r;

  // Next-state logic and handshake outputs for the transaction FSM
  always_comb begin
    state_n         = state_r;
    rr_n            = rr_r;
    owner_n         = owner_r;
    cnt_n           = cnt_r;
    timed_out_n     = timed_out_r;
    addr_n          = addr_r;
    we_n            = we_r;
    wdata_n         = wdata_r;
    rdata_n         = rdata_r;
    err_n           = err_r;
    req_ready_and_o = '0;
    host_req_o      = 1'b0;
    resp_v_o        = '0;
    case (state_r)
      IDLE: begin
        // A grant is withheld while reset is asserted, so no requester sees
        // an accept that the reset would then discard.
        if (grant_found && rst_ni) begin
          req_ready_and_o = num_req_p'(1) << grant_idx;
          owner_n         = grant_idx;
          rr_n            = rr_w_lp'((32'(grant_idx) + 32'd1) % num_req_p);
          addr_n          = sel_addr;
          we_n            = sel_we;
          wdata_n         = sel_wdata;
          timed_out_n     = 1'b0;
          state_n         = ISSUE;
        end
      end
      ISSUE: begin
        host_req_o = 1'b1;
        if (host_gnt_i) begin
          cnt_n   = '0;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (host_valid_i) begin
          rdata_n     = host_rdata_i;
          err_n       = host_err_i;
          timed_out_n = 1'b0;
          state_n     = RESP;
        end else if (cnt_r == cnt_last_lp) begin
          rdata_n     = '0;
          err_n       = 1'b1;
          timed_out_n = 1'b1;
          state_n     = RESP;
        end else begin
          cnt_n = cnt_r + 1'b1;
        end
      end
      RESP: begin
        resp_v_o = owner_mask;
        // A late host response arriving here is absorbed and cancels the drain.
        if (host_valid_i) timed_out_n = 1'b0;
        if ((resp_ready_and_i & owner_mask) != '0) begin
          state_n = (timed_out_r && !host_valid_i) ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (host_valid_i) begin
          timed_out_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      rr_r        <= '0;
      owner_r     <= '0;
      cnt_r       <= '0;
      timed_out_r <= 1'b0;
      addr_r      <= '0;
      we_r        <= 1'b0;
      wdata_r     <= '0;
      rdata_r     <= '0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_n;
      rr_r        <= rr_n;
      owner_r     <= owner_n;
      cnt_r       <= cnt_n;
      timed_out_r <= timed_out_n;
      addr_r      <= addr_n;
      we_r        <= we_n;
      wdata_r     <= wdata_n;
      rdata_r     <= rdata_n;
      err_r       <= err_n;
    end
  end

  assign host_addr_o  = addr_r;
  assign host_we_o    = we_r;
  assign host_wdata_o = wdata_r;
  assign host_be_o    = '1;
  assign resp_rdata_o = rdata_r;
  assign resp_err_o   = err_r;

endmodule

// File: tb/tb_plic_reg_arbiter.sv
// Self-checking bench for plic_reg_arbiter. It is transaction-driven: each
// transaction's phases are played in order, and outputs are checked every
// cycle against expectations derived from round-robin and timeout rules.
module tb_plic_reg_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int T  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_v, req_ready, req_we, resp_v, resp_ready;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [DW-1:0]     resp_rdata, host_wdata, host_rdata;
  logic              resp_err, host_req, host_gnt, host_we, host_valid, host_err;
  logic [AW-1:0]     host_addr;
  logic [DW/8-1:0]   host_be;
  logic [DW/8-1:0]   be_ones;

  int n_cmp = 0;
  int n_err = 0;
  int rr_m  = 0;

  plic_reg_arbiter #(
    .addr_width_p(AW), .data_width_p(DW), .num_req_p(N), .timeout_cycles_p(T)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_v_i(req_v), .req_ready_and_o(req_ready), .req_addr_i(req_addr),
    .req_we_i(req_we), .req_wdata_i(req_wdata),
    .resp_v_o(resp_v), .resp_ready_and_i(resp_ready),
    .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .host_req_o(host_req), .host_gnt_i(host_gnt), .host_addr_o(host_addr),
    .host_we_o(host_we), .host_wdata_o(host_wdata), .host_be_o(host_be),
    .host_valid_i(host_valid), .host_rdata_i(host_rdata), .host_err_i(host_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [N-1:0] m, input int rr);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (rr + k) % N;
      if (m[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic scramble_reqs();
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = $urandom();
      req_wdata[i*DW +: DW] = $urandom();
      req_we[i]             = 1'($urandom());
    end
  endtask

  task automatic chk_quiet(input string ph);
    chk({ph, "_ready"}, req_ready, '0);
    chk({ph, "_hreq"}, host_req, 0);
    chk({ph, "_respv"}, resp_v, '0);
  endtask

  // val_dly < 0: host never answers. rst_wait >= 0: reset in that WAIT cycle.
  task automatic run_txn(input logic [N-1:0] mask, input int gnt_dly, input int val_dly,
                         input int rdy_dly, input int late_dly, input int gap,
                         input int rst_wait);
    int w;
    logic [N-1:0] exp_m;
    logic [AW-1:0] e_addr;
    logic e_we, e_err, tmo, got;
    logic [DW-1:0] e_wd, e_rd;

    for (int g = 0; g < gap; g++) begin
      req_v = '0; host_valid = 1'($urandom()); resp_ready = N'($urandom());
      @(negedge clk);
      chk_quiet("gap");
      tick();
    end

    // Acceptance
    scramble_reqs();
    req_v = mask; host_gnt = 1'b0; host_valid = 1'($urandom());
    resp_ready = N'($urandom());
    w = pick(mask, rr_m);
    exp_m = '0; exp_m[w] = 1'b1;
    e_addr = req_addr[w*AW +: AW];
    e_we   = req_we[w];
    e_wd   = req_wdata[w*DW +: DW];
    @(negedge clk);
    chk("idle_ready", req_ready, exp_m);
    chk("idle_hreq", host_req, 0);
    tick();
    rr_m = (w + 1) % N;

    // Issue to host; requester inputs change to prove the fields were captured
    for (int k = 0; k <= gnt_dly; k++) begin
      scramble_reqs();
      req_v = N'($urandom()); host_gnt = (k == gnt_dly); host_valid = 1'($urandom());
      @(negedge clk);
      chk("iss_hreq", host_req, 1);
      chk("iss_addr", host_addr, e_addr);
      chk("iss_we", host_we, e_we);
      chk("iss_wdata", host_wdata, e_wd);
      chk("iss_be", host_be, be_ones);
      chk("iss_ready", req_ready, '0);
      tick();
    end
    host_gnt = 1'b0;

    // Wait for host response or timeout
    got = 1'b0; e_rd = '0; e_err = 1'b1; tmo = 1'b0;
    for (int k = 0; k < T; k++) begin
      if (k == rst_wait) begin
        req_v = '1; host_valid = 1'b0; rst_n = 1'b0;
        tick();
        @(negedge clk);
        chk("rst_ready", req_ready, '0);
        chk("rst_hreq", host_req, 0);
        chk("rst_respv", resp_v, '0);
        chk("rst_addr", host_addr, '0);
        chk("rst_wdata", host_wdata, '0);
        chk("rst_we", host_we, 0);
        chk("rst_rdata", resp_rdata, '0);
        chk("rst_err", resp_err, 0);
        chk("rst_be", host_be, be_ones);
        tick();
        req_v = '0; rst_n = 1'b1;
        @(negedge clk);
        chk_quiet("post_rst");
        tick();
        rr_m = 0;
        return;
      end
      host_valid = (k == val_dly);
      host_rdata = $urandom(); host_err = 1'($urandom());
      if (host_valid) begin e_rd = host_rdata; e_err = host_err; end
      req_v = N'($urandom());
      @(negedge clk);
      chk_quiet("wait");
      tick();
      if (k == val_dly) begin got = 1'b1; break; end
    end
    tmo = !got;

    // Response to the owning requester
    for (int k = 0; k <= rdy_dly; k++) begin
      resp_ready = N'($urandom()); resp_ready[w] = (k == rdy_dly);
      host_valid = tmo && (k == late_dly);
      host_rdata = $urandom();
      req_v = N'($urandom());
      @(negedge clk);
      chk("resp_v", resp_v, exp_m);
      chk("resp_rdata", resp_rdata, e_rd);
      chk("resp_err", resp_err, e_err);
      chk("resp_ready", req_ready, '0);
      tick();
    end

    // Drain a late response after a timeout
    if (tmo && late_dly > rdy_dly) begin
      for (int k = rdy_dly + 1; k <= late_dly; k++) begin
        host_valid = (k == late_dly);
        req_v = N'($urandom());
        @(negedge clk);
        chk_quiet("drain");
        tick();
      end
    end
    host_valid = 1'b0;
    req_v = '0;
  endtask

  initial begin
    be_ones = '1;
    rst_n = 1'b0; req_v = '1; req_addr = '0; req_we = '0; req_wdata = '0;
    resp_ready = '0; host_gnt = 1'b0; host_valid = 1'b0; host_rdata = '0; host_err = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("reset_ready", req_ready, '0);
    chk("reset_hreq", host_req, 0);
    chk("reset_respv", resp_v, '0);
    chk("reset_addr", host_addr, '0);
    chk("reset_rdata", resp_rdata, '0);
    chk("reset_err", resp_err, 0);
    chk("reset_be", host_be, be_ones);
    tick();
    req_v = '0; rst_n = 1'b1;
    tick();

    // Best-case latency: grant and valid both immediate
    run_txn(3'b001, 0, 0, 0, 0, 0, -1);
    // Two requesters continuously valid alternate
    for (int i = 0; i < 4; i++) run_txn(3'b011, 0, 1, 0, 0, 0, -1);
    // Host grant held off for five cycles
    run_txn(3'b010, 5, 2, 1, 0, 0, -1);
    // Timeout with a late response drained after the handshake
    run_txn(3'b100, 1, -1, 1, 3, 0, -1);
    // Timeout with late response arriving during RESP (no drain)
    run_txn(3'b001, 0, -1, 2, 1, 1, -1);
    // Host valid in the same cycle as timeout wins
    run_txn(3'b110, 0, T - 1, 0, 0, 0, -1);

    for (int n = 0; n < 60; n++) begin
      int vd;
      vd = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, T - 1));
      run_txn(N'($urandom_range(1, (1 << N) - 1)), int'($urandom_range(0, 4)), vd,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
              int'($urandom_range(0, 2)), -1);
    end

    // Reset in WAIT after rr has advanced, then req0/req1 must give req0 first
    run_txn(3'b001, 0, 0, 0, 0, 0, -1);
    run_txn(3'b010, 0, -1, 0, 0, 0, 2);
    run_txn(3'b011, 0, 0, 0, 0, 0, -1);
    run_txn(3'b010, 0, 0, 0, 0, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/plic_reg_arbiter.md
PLIC_REG_ARBITER -- requirements
Module: plic_reg_arbiter

Interface
REQ-001 SHALL have parameter addr_width_p, default 32, meaning request address width.
REQ-002 SHALL have parameter data_width_p, default 32, meaning register data width.
REQ-003 SHALL have parameter num_req_p, default 2, meaning number of requesters (legal range 2-8).
REQ-004 SHALL have parameter timeout_cycles_p, default 1024, meaning maximum cycles spent waiting for a host response (legal range >= 2).
REQ-005 SHALL have port clk_i  input  1  clock; the block uses only this one clock.
REQ-006 SHALL have port rst_ni  input  1  reset, synchronous and active-low.
REQ-007 SHALL have port req_v_i  input  num_req_p  per-requester request valid.
REQ-008 SHALL have port req_ready_and_o  output  num_req_p  per-requester request accept.
REQ-009 SHALL have port req_addr_i  input  num_req_p*addr_width_p  packed addresses; requester i occupies slice i.
REQ-010 SHALL have port req_we_i  input  num_req_p  1 = write, 0 = read.
REQ-011 SHALL have port req_wdata_i  input  num_req_p*data_width_p  packed write data.
REQ-012 SHALL have port resp_v_o  output  num_req_p  one-hot response valid.
REQ-013 SHALL have port resp_ready_and_i  input  num_req_p  per-requester response accept.
REQ-014 SHALL have port resp_rdata_o  output  data_width_p  shared response data.
REQ-015 SHALL have port resp_err_o  output  1  response error flag.
REQ-016 SHALL have the following host-side ports:
- host_req_o  output  1
- host_gnt_i  input  1
- host_addr_o  output  addr_width_p
- host_we_o  output  1
- host_wdata_o  output  data_width_p
- host_be_o  output  data_width_p/8
- host_valid_i  input  1
- host_rdata_i  input  data_width_p
- host_err_i  input  1

Function
REQ-017 SHALL allow at most one transaction outstanding at a time.
REQ-018 SHALL implement an FSM with states IDLE, ISSUE, WAIT, RESP and DRAIN.
REQ-019 SHALL, in IDLE, select one requester with req_v_i set by round-robin starting at pointer rr_r, assert req_ready_and_o only for that requester, capture its addr/we/wdata and go to ISSUE.
REQ-020 SHALL keep req_ready_and_o all-zero in every state except IDLE.
REQ-021 SHALL, after a grant to requester i, set rr_r to (i+1) mod num_req_p.
REQ-022 SHALL, in ISSUE, drive host_req_o=1 with the captured fields and host_be_o all-ones, holding them stable until host_gnt_i=1, then go to WAIT; host_req_o SHALL be 0 in all other states.
REQ-023 SHALL, in WAIT, increment a timeout counter from 0 each cycle.
REQ-024 SHALL, on host_valid_i=1 in WAIT, register host_rdata_i and host_err_i and go to RESP.
REQ-025 SHALL, when the timeout counter reaches timeout_cycles_p-1 without host_valid_i, go to RESP with rdata=0, err=1 and set timed_out_r.
REQ-026 SHALL give host_valid_i priority over timeout when both occur in the same cycle.
REQ-027 SHALL, in RESP, assert resp_v_o only for the owning requester, with resp_rdata_o and resp_err_o held stable until resp_ready_and_i for that requester is 1.
REQ-028 SHALL, on the RESP handshake, go to DRAIN if timed_out_r=1, otherwise to IDLE.
REQ-029 SHALL clear timed_out_r when host_valid_i=1 arrives in RESP or DRAIN, discarding that response, and SHALL leave DRAIN for IDLE in the cycle host_valid_i=1.
REQ-030 SHALL ignore host_valid_i in IDLE and ISSUE.
REQ-031 SHALL have a best-case latency from request acceptance to resp_v_o of 3 cycles (gnt in the first ISSUE cycle, valid in the first WAIT cycle).
REQ-032 SHALL size the timeout counter as $clog2(timeout_cycles_p) bits, with no wrap-around possible.

Reset
REQ-033 SHALL, while rst_ni=0 at a clock edge, force state=IDLE, rr_r=0, timed_out_r=0, counter=0, captured registers=0.
REQ-034 SHALL drive all outputs to 0 during and immediately after reset, except host_be_o, which SHALL be all-ones.
REQ-035 SHALL abandon any in-flight transaction on reset, with no response issued and no drain performed.

Verification
REQ-036 SHALL pass this scenario: req0 write addr 0x4, data 0x7; gnt in cycle 1; valid in WAIT cycle 1 -> resp_v_o=01 three cycles after accept, err=0.
REQ-037 SHALL pass this scenario: req0 and req1 held continuously valid -> grants alternate 0,1,0,1 from reset.
REQ-038 SHALL pass this scenario: host_gnt_i held low for 5 cycles -> host_req_o/addr/wdata stable for 6 cycles, req_ready_and_o=00 throughout.
REQ-039 SHALL pass this scenario: read with host_valid_i never returned, timeout_cycles_p=8 -> resp_err_o=1, rdata=0 after 8 WAIT cycles; FSM enters DRAIN; a late valid returns to IDLE with no resp_v_o.
REQ-040 SHALL pass this scenario: host_valid_i in the same cycle as timeout -> normal response with host data, err=host_err_i, no DRAIN.
REQ-041 SHALL pass this scenario: rst_ni=0 asserted in WAIT -> next cycle all outputs 0, req1 then granted first from rr_r=0 order (req0 if both are valid).
